// File: rtl/usart_rx_buffer.sv
// usart_rx_buffer
//   Receive-side buffer for a USART. Accepts frames from the receiver stage
//   through a level handshake (rx_available/rx_error -> rx_acknowledge). It
//   stores good bytes in a DEPTH-entry FIFO and keeps sticky overrun and
//   framing-error flags.
//
// Ports
//   i_comm_clock      sole clock, rising edge
//   i_reset_n         synchronous active-low reset
//   i_rx_data         received byte
//   i_rx_available    level: good frame waiting
//   i_rx_error        level: frame with bad stop bit waiting
//   o_rx_acknowledge  level: frame consumed
//   i_read_strobe     pop head entry (ignored when empty)
//   o_data_out        head entry, 8'h00 when empty
//   o_data_valid      FIFO not empty
//   o_count           stored entries, 0..DEPTH
//   o_overrun         sticky: good byte dropped because FIFO full
//   o_framing_error   sticky: errored frame received
//   i_clear_errors    clear both sticky flags
module usart_rx_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_comm_clock,
  input  logic          i_reset_n,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_available,
  input  logic          i_rx_error,
  output logic          o_rx_acknowledge,
  input  logic          i_read_strobe,
  output logic [7:0]    o_data_out,
  output logic          o_data_valid,
  output logic [AW:0]   o_count,
  output logic          o_overrun,
  output logic          o_framing_error,
  input  logic          i_clear_errors
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StRelease
  } state_e;

  state_e        r_state, w_state_d;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_overrun, r_framing_error;

  logic          w_full, w_empty;
  logic          w_pop, w_push;
  logic          w_set_overrun, w_set_framing;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FullCount);
  assign w_pop   = i_read_strobe && !w_empty;

  // Handshake FSM: next state plus push/flag-set decode
  always_comb begin
    w_state_d     = r_state;
    w_push        = 1'b0;
    w_set_overrun = 1'b0;
    w_set_framing = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_rx_error) begin
          w_set_framing = 1'b1;
          w_state_d     = StAck;
        end else if (i_rx_available) begin
          // A pop in the same cycle frees a slot, so a full FIFO still accepts.
          if (!w_full || w_pop) begin
            w_push = 1'b1;
          end else begin
            w_set_overrun = 1'b1;
          end
          w_state_d = StAck;
        end
      end
      StAck: begin
        if (!i_rx_available && !i_rx_error) begin
          w_state_d = StRelease;
        end
      end
      StRelease: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_comm_clock) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge i_comm_clock) begin
    if (!i_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge i_comm_clock) begin
    if (i_reset_n && w_push) begin
      r_mem[r_wptr] <= i_rx_data;
    end
  end

  // Sticky flags: a set event beats a simultaneous clear
  always_ff @(posedge i_comm_clock) begin
    if (!i_reset_n) begin
      r_overrun       <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      if (w_set_overrun) begin
        r_overrun <= 1'b1;
      end else if (i_clear_errors) begin
        r_overrun <= 1'b0;
      end
      if (w_set_framing) begin
        r_framing_error <= 1'b1;
      end else if (i_clear_errors) begin
        r_framing_error <= 1'b0;
      end
    end
  end

  assign o_rx_acknowledge = (r_state == StAck);
  assign o_data_valid     = !w_empty;
  assign o_data_out       = w_empty ? 8'h00 : r_mem[r_rptr];
  assign o_count          = r_count;
  assign o_overrun        = r_overrun;
  assign o_framing_error  = r_framing_error;

endmodule

// File: doc/usart_rx_buffer.md
USART_RX_BUFFER -- requirements
Module: usart_rx_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of 2, minimum 2.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 comm_clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset, sampled on comm_clock rising edge.
REQ-005 rx_data  in  8  received byte from the receiver stage.
REQ-006 rx_available  in  1  level; a good frame is waiting.
REQ-007 rx_error  in  1  level; a frame with a bad stop bit is waiting.
REQ-008 rx_acknowledge  out  1  level; the frame has been consumed.
REQ-009 read_strobe  in  1  pops the head entry when data_valid=1.
REQ-010 data_out  out  8  head entry.
REQ-011 data_valid  out  1  FIFO not empty.
REQ-012 count  out  AW+1  number of stored entries, 0..DEPTH.
REQ-013 overrun  out  1  sticky; a good byte was dropped because the FIFO was full.
REQ-014 framing_error  out  1  sticky; an errored frame was received.
REQ-015 clear_errors  in  1  clears overrun and framing_error.

Function
REQ-016 The receive handshake SHALL use three states: IDLE, ACK, RELEASE.
REQ-017 IDLE, rx_error=1: SHALL discard rx_data, set framing_error, drive rx_acknowledge=1, and go to ACK (rx_error takes priority over rx_available).
REQ-018 IDLE, rx_available=1, rx_error=0: SHALL push rx_data if the FIFO is not full, else set overrun; SHALL drive rx_acknowledge=1 and go to ACK.
REQ-019 ACK: rx_acknowledge SHALL stay 1 until rx_available=0 and rx_error=0 are both sampled, then SHALL go to RELEASE with rx_acknowledge=0.
REQ-020 RELEASE: SHALL return to IDLE after one cycle, giving at least one low cycle of rx_acknowledge between acknowledges.
REQ-021 No push SHALL occur outside IDLE; each frame SHALL be pushed at most once.
REQ-022 Push latency: the byte SHALL be written on the edge where IDLE samples rx_available; data_valid and count SHALL reflect it immediately after that edge.
REQ-023 data_out SHALL equal the entry at the read pointer while data_valid=1, and SHALL be 8'h00 while empty.
REQ-024 Pop: read_strobe=1 with data_valid=1 SHALL advance the read pointer by one and decrement count.
REQ-025 read_strobe while empty SHALL be ignored, with no pointer or count change.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 full SHALL mean count==DEPTH.
REQ-028 Simultaneous push and pop while not empty: both SHALL occur and count SHALL be unchanged.
REQ-029 Simultaneous push and pop while full: both SHALL occur, count SHALL stay DEPTH, and overrun SHALL NOT be set.
REQ-030 Simultaneous push and pop while empty: the push SHALL occur, the pop SHALL be ignored, and count SHALL become 1.
REQ-031 clear_errors SHALL clear both sticky flags on the next edge.
REQ-032 A set event in the same cycle as clear_errors SHALL win, leaving that flag at 1.
REQ-033 count SHALL never exceed DEPTH and SHALL never underflow.

Reset
REQ-034 While reset_n=0 at a rising edge: state SHALL go to IDLE, and rx_acknowledge, overrun, framing_error and count SHALL be 0.
REQ-035 While reset_n=0 at a rising edge: both pointers SHALL be 0 and data_valid=0.
REQ-036 Reset SHALL override all simultaneous push, pop and clear activity.
REQ-037 Reset asserted while in ACK SHALL drop rx_acknowledge on that edge.
REQ-038 FIFO memory contents need not be reset.
REQ-039 If rx_available is still high after reset release, it SHALL be treated as a new frame.

Verification
REQ-040 Single byte: reset; rx_available=1 with rx_data=8'hA5, held until acknowledged -> rx_acknowledge rises one edge later; data_valid=1, data_out=8'hA5, count=1.
REQ-041 Pop: from the state of REQ-040, read_strobe=1 for one cycle -> data_valid=0, data_out=8'h00, count=0.
REQ-042 Framing: rx_error=1 with rx_data=8'h3C -> framing_error=1, count unchanged, rx_acknowledge asserted.
REQ-043 Clear: after REQ-042, clear_errors=1 -> framing_error=0 on the next edge.
REQ-044 Overrun: push 8'h00..8'h0F with DEPTH=16 -> count=16; a 17th frame 8'hFF is acknowledged, overrun=1, and pops then return 8'h00..8'h0F in order.
REQ-045 Full boundary: with count=16, a frame arrives with read_strobe=1 in the IDLE-capture cycle -> count=16, overrun=0, and the new byte appears after 15 further pops.
REQ-046 Reset in ACK: reset_n=0 while rx_acknowledge=1 -> rx_acknowledge=0, count=0 after that edge.
